// File: rtl/parallel_to_serial.sv
// parallel_to_serial
// Serializer: takes a width-bit word over a valid/ready handshake and emits
// it one bit per transfer, MSB first, with serial_last marking bit 0.
// Optional macro PARALLEL_TO_SERIAL_SKID_BUFFER_EN adds a one-word holding
// buffer so back-to-back words stream with no idle cycle between them.
// Without the macro a word is only accepted while the shifter is idle.

module parallel_to_serial #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             parallel_valid,
  output logic             parallel_ready,
  input  logic [width-1:0] parallel_data,
  output logic             serial_valid,
  input  logic             serial_ready,
  output logic             serial_data,
  output logic             serial_last
);

  localparam int CntW = $clog2(width);
  localparam logic [CntW-1:0] LastCnt = CntW'(width - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [width-1:0] sh_q, sh_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic accept;
  logic xfer;
  logic atLastBit;

`ifdef PARALLEL_TO_SERIAL_SKID_BUFFER_EN
  logic [width-1:0] buf_q, buf_d;
  logic             buf_full_q, buf_full_d;
`endif

  // The serial side is valid exactly while a word is being shifted; data and
  // last are forced low outside SHIFT so the idle line is clean.
  assign serial_valid = (state_q == SHIFT);
  assign serial_data  = serial_valid & sh_q[width-1];
  assign atLastBit    = (cnt_q == LastCnt);
  assign serial_last  = serial_valid & atLastBit;

  // Upstream ready comes from registered state and rst only, so there is no
  // combinational path from either handshake input.
`ifdef PARALLEL_TO_SERIAL_SKID_BUFFER_EN
  assign parallel_ready = !rst && !buf_full_q;
`else
  assign parallel_ready = !rst && (state_q == IDLE);
`endif

  assign accept = parallel_valid && parallel_ready;
  assign xfer   = serial_valid && serial_ready;

  // Next-state logic: load on accept, shift on transfer, and on the last bit
  // either reload (buffered or coincident word) or fall back to IDLE.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
`ifdef PARALLEL_TO_SERIAL_SKID_BUFFER_EN
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          sh_d    = parallel_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
`ifdef PARALLEL_TO_SERIAL_SKID_BUFFER_EN
        // A word arriving mid-word parks in the buffer; one arriving exactly
        // on the last-bit transfer with an empty buffer goes straight to sh.
        if (accept && !(xfer && atLastBit)) begin
          buf_d      = parallel_data;
          buf_full_d = 1'b1;
        end
`endif
        if (xfer) begin
          if (!atLastBit) begin
            sh_d  = {sh_q[width-2:0], 1'b0};
            cnt_d = cnt_q + CntW'(1);
          end else begin
`ifdef PARALLEL_TO_SERIAL_SKID_BUFFER_EN
            if (buf_full_q) begin
              sh_d       = buf_q;
              cnt_d      = '0;
              buf_full_d = 1'b0;
            end else if (accept) begin
              sh_d  = parallel_data;
              cnt_d = '0;
            end else begin
              sh_d    = {sh_q[width-2:0], 1'b0};
              cnt_d   = '0;
              state_d = IDLE;
            end
`else
            sh_d    = {sh_q[width-2:0], 1'b0};
            cnt_d   = '0;
            state_d = IDLE;
`endif
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; synchronous reset drops any partial or buffered word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
`ifdef PARALLEL_TO_SERIAL_SKID_BUFFER_EN
      buf_q      <= '0;
      buf_full_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
`ifdef PARALLEL_TO_SERIAL_SKID_BUFFER_EN
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
`endif
    end
  end

endmodule

// File: tb/tb_parallel_to_serial.sv
// tb_parallel_to_serial
// Scoreboard bench for parallel_to_serial (width 8). Each accepted word pushes
// its eight expected bits into a queue; a monitor pops and compares on every
// serial transfer. Honors PARALLEL_TO_SERIAL_SKID_BUFFER_EN for gap checks.

module tb_parallel_to_serial;

  localparam int Width = 8;
`ifdef PARALLEL_TO_SERIAL_SKID_BUFFER_EN
  localparam int ExpGaps = 0;
`else
  localparam int ExpGaps = 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             parallel_valid;
  logic             parallel_ready;
  logic [Width-1:0] parallel_data;
  logic             serial_valid;
  logic             serial_ready;
  logic             serial_data;
  logic             serial_last;

  typedef struct {
    logic data;
    logic last;
  } bitExp_t;

  bitExp_t expQ[$];
  int checkCount = 0;
  int passCount  = 0;

  parallel_to_serial #(.width(Width)) dut (
    .clk            (clk),
    .rst            (rst),
    .parallel_valid (parallel_valid),
    .parallel_ready (parallel_ready),
    .parallel_data  (parallel_data),
    .serial_valid   (serial_valid),
    .serial_ready   (serial_ready),
    .serial_data    (serial_data),
    .serial_last    (serial_last)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Offer one word and wait for it to be accepted; push its bits on accept.
  task automatic applyStimulus(input logic [Width-1:0] word);
    int waited = 0;
    bit done = 0;
    parallel_valid = 1'b1;
    parallel_data  = word;
    while (!done && waited < 50) begin
      @(negedge clk);
      if (parallel_ready) begin
        @(posedge clk);
        for (int i = Width - 1; i >= 0; i--) begin
          bitExp_t e;
          e.data = word[i];
          e.last = (i == 0);
          expQ.push_back(e);
        end
        done = 1;
        #1;
      end else begin
        waited++;
      end
    end
    parallel_valid = 1'b0;
    parallel_data  = Width'($urandom);
    if (!done) begin
      checkCount++;
      $display("[TB] FAIL acceptTimeout: word %0h not accepted, expected accept within 50 cycles", word);
    end
  endtask

  // Wait for the scoreboard to empty, then confirm the serial side goes idle.
  task automatic waitDrain(input int maxCycles);
    int n = 0;
    while (expQ.size() != 0 && n < maxCycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain", expQ.size(), 0);
    @(negedge clk);
    checkOutput("validAfterWord", serial_valid, 0);
  endtask

  // Monitor: pop on transfer, compare against queue head during stalls, and
  // require a quiet data line while nothing is valid.
  always @(negedge clk) begin
    if (!rst) begin
      if (serial_valid) begin
        if (expQ.size() == 0) begin
          if (serial_ready) begin
            checkCount++;
            $display("[TB] FAIL unexpectedBit: got data %0b last %0b, expected no transfer", serial_data, serial_last);
          end
        end else if (serial_ready) begin
          bitExp_t e;
          e = expQ.pop_front();
          checkOutput("bitData", serial_data, e.data);
          checkOutput("bitLast", serial_last, e.last);
        end else begin
          checkOutput("stallData", serial_data, expQ[0].data);
          checkOutput("stallLast", serial_last, expQ[0].last);
        end
      end else begin
        checkOutput("idleDataLow", {serial_data, serial_last}, 0);
      end
    end
  end

  initial begin
    logic [13:0] stallPat;
    rst            = 1'b1;
    parallel_valid = 1'b0;
    parallel_data  = '0;
    serial_ready   = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rstValid", serial_valid, 0);
    checkOutput("rstReady", parallel_ready, 0);
    checkOutput("rstData", serial_data, 0);
    checkOutput("rstLast", serial_last, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("readyAfterReset", parallel_ready, 1);

    // Idle with toggling data: nothing must come out
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      parallel_data = (i % 2 == 0) ? 8'hAA : 8'h55;
      @(negedge clk);
      checkOutput("idleValid", serial_valid, 0);
      checkOutput("idleReady", parallel_ready, 1);
    end
    @(posedge clk);
    #1;

    // Single word A5 with latency check
    $display("[TB] single word 8'hA5");
    applyStimulus(8'hA5);
    @(negedge clk);
    checkOutput("firstBitValid", serial_valid, 1);
    checkOutput("firstBitMsb", serial_data, 1);
    waitDrain(20);

    // Backpressure on word C3: stall 3 cycles at bit 2 and at bit 7
    $display("[TB] backpressure 8'hC3");
    @(posedge clk);
    #1;
    stallPat = 14'b11000111110001;
    applyStimulus(8'hC3);
    for (int i = 0; i < 14; i++) begin
      serial_ready = stallPat[13-i];
      @(posedge clk);
      #1;
    end
    serial_ready = 1'b1;
    waitDrain(20);

    // Back-to-back FF then 00, counting idle gaps between them
    $display("[TB] back-to-back 8'hFF, 8'h00");
    @(posedge clk);
    #1;
    fork
      begin
        applyStimulus(8'hFF);
        applyStimulus(8'h00);
      end
      begin
        int xfers = 0;
        int gaps = 0;
        int cyc = 0;
        bit started = 0;
        while (xfers < 16 && cyc < 60) begin
          @(negedge clk);
          cyc++;
          if (serial_valid) begin
            started = 1;
            if (serial_ready) xfers++;
          end else if (started) begin
            gaps++;
          end
        end
        checkOutput("b2bTransfers", xfers, 16);
        checkOutput("b2bGaps", gaps, ExpGaps);
      end
    join
    waitDrain(20);

    // Reset mid-word after 3 bits of 5A (plus buffered 81 when enabled)
    $display("[TB] reset mid-word");
    @(posedge clk);
    #1;
    applyStimulus(8'h5A);
`ifdef PARALLEL_TO_SERIAL_SKID_BUFFER_EN
    applyStimulus(8'h81);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
`else
    repeat (3) begin
      @(posedge clk);
      #1;
    end
`endif
    rst = 1'b1;
    expQ.delete();
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("midRstValid", serial_valid, 0);
    checkOutput("midRstReady", parallel_ready, 0);
    checkOutput("midRstData", serial_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("readyAfterMidRst", parallel_ready, 1);
    checkOutput("validAfterMidRst", serial_valid, 0);
    @(posedge clk);
    #1;
    applyStimulus(8'h3C);
    waitDrain(20);

    checkOutput("queueEmpty", expQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
